// File: rtl/systolic_sample_feeder.sv
// Sample sequencer for the systolic interpolation PE chain: buffers source words,
// issues one word per programmable-length slot, and captures the frame result.
module systolic_sample_feeder #(
  parameter int WORDLENGTH = 16,
  parameter int TAPS       = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk30x,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [WORDLENGTH-1:0]   in_word,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             period,
  output logic [WORDLENGTH-1:0]   pe_word,
  output logic [2:0]              pe_index,
  output logic                    pe_strobe,
  input  logic [WORDLENGTH-1:0]   pe_result,
  output logic [WORDLENGTH-1:0]   result_word,
  output logic                    result_valid,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [2:0]    LAST_TAP   = 3'(TAPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [WORDLENGTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;

  // Sequencer state
  state_t                state_q;
  logic [31:0]           slot_cnt_q;
  logic [31:0]           slot_len_q;
  logic [WORDLENGTH-1:0] pe_word_q;
  logic [2:0]            pe_index_q;
  logic                  pe_strobe_q;
  logic [WORDLENGTH-1:0] result_word_q;
  logic                  result_valid_q;

  logic fifo_empty;
  logic slot_end;
  logic push;
  logic pop;

  // Full is judged on the registered level only, so a same-cycle pop never
  // reopens in_ready; this keeps in_ready free of any path from the sequencer.
  assign in_ready = (level_q != FULL_LEVEL);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    level_d    = level_q;
    fifo_empty = (level_q == '0);
    slot_end   = (state_q == SLOT) && (slot_cnt_q == slot_len_q);
    push       = in_valid && in_ready && !clear;
    pop        = !clear && !fifo_empty && ((state_q == IDLE) || slot_end);
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk30x or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // NOTE: the storage array has no reset; a word is only ever read after it is
  // written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk30x) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  always_ff @(posedge clk30x or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      slot_cnt_q     <= '0;
      slot_len_q     <= '0;
      pe_word_q      <= '0;
      pe_index_q     <= '0;
      pe_strobe_q    <= 1'b0;
      result_word_q  <= '0;
      result_valid_q <= 1'b0;
    end else begin
      pe_strobe_q    <= 1'b0;
      result_valid_q <= 1'b0;
      if (clear) begin
        state_q    <= IDLE;
        slot_cnt_q <= '0;
        pe_index_q <= '0;
      end else begin
        // Slot end: retire the current tap, capturing the frame on the last one.
        if (slot_end) begin
          if (pe_index_q == LAST_TAP) begin
            result_word_q  <= pe_result;
            result_valid_q <= 1'b1;
          end
          pe_index_q <= pe_index_q + 3'd1;
        end

        if (pop) begin
          pe_word_q   <= mem_q[rd_ptr_q];
          pe_strobe_q <= 1'b1;
          slot_len_q  <= period;
          slot_cnt_q  <= '0;
          state_q     <= SLOT;
        end else if (state_q == SLOT) begin
          if (slot_end) begin
            state_q <= IDLE;
          end else begin
            slot_cnt_q <= slot_cnt_q + 32'd1;
          end
        end
      end
    end
  end

  assign pe_word      = pe_word_q;
  assign pe_index     = pe_index_q;
  assign pe_strobe    = pe_strobe_q;
  assign result_word  = result_word_q;
  assign result_valid = result_valid_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_systolic_sample_feeder.sv
// Directed bench for systolic_sample_feeder; edge numbers count rising edges
// after reset release, and outputs are sampled 1 time unit after each edge.
module tb_systolic_sample_feeder;

  logic        clk30x = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] period = '0;
  logic [15:0] pe_word;
  logic [2:0]  pe_index;
  logic        pe_strobe;
  logic [15:0] pe_result = '0;
  logic [15:0] result_word;
  logic        result_valid;
  logic [4:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_sample_feeder #(.WORDLENGTH(16), .TAPS(8), .DEPTH(16)) dut (
    .clk30x      (clk30x),
    .reset       (reset),
    .clear       (clear),
    .in_word     (in_word),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .period      (period),
    .pe_word     (pe_word),
    .pe_index    (pe_index),
    .pe_strobe   (pe_strobe),
    .pe_result   (pe_result),
    .result_word (result_word),
    .result_valid(result_valid),
    .fifo_level  (fifo_level)
  );

  always #5 clk30x = ~clk30x;

  task automatic tick();
    @(posedge clk30x);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    repeat (2) @(posedge clk30x);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk30x);
    #1;
    n_checks++;
    if (pe_word !== 16'h0 || pe_index !== 3'd0 || pe_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pe: word %h idx %0d strobe %b, want 0 0 0", pe_word, pe_index, pe_strobe);
    end
    n_checks++;
    if (result_word !== 16'h0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result: word %h valid %b, want 0 0", result_word, result_valid);
    end
    n_checks++;
    if (fifo_level !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fifo: level %0d ready %b, want 0 1", fifo_level, in_ready);
    end
  endtask

  task automatic test_single_frame();
    int n_str, n_res, res_cyc;
    apply_reset();
    period    = 32'd3;
    pe_result = 16'h00A5;
    n_str = 0; n_res = 0; res_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      in_valid = (c <= 8);
      in_word  = 16'(c);
      tick();
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL single_ready: edge %0d ready %b, want 1", c, in_ready);
      end
      if (pe_strobe === 1'b1) begin
        n_checks++;
        if (c != 2 + 4 * n_str || pe_word !== 16'(n_str + 1) || pe_index !== 3'(n_str)) begin
          n_fail++;
          $display("FAIL single_strobe%0d: edge %0d word %h idx %0d, want edge %0d word %h idx %0d",
                   n_str, c, pe_word, pe_index, 2 + 4 * n_str, 16'(n_str + 1), n_str);
        end
        n_str++;
      end
      if (result_valid === 1'b1) begin
        n_res++;
        res_cyc = c;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_str != 8) begin
      n_fail++;
      $display("FAIL single_strobe_count: %0d, want 8", n_str);
    end
    n_checks++;
    if (n_res != 1 || res_cyc != 34) begin
      n_fail++;
      $display("FAIL single_result_pulse: count %0d at edge %0d, want 1 at edge 34", n_res, res_cyc);
    end
    n_checks++;
    if (result_word !== 16'h00A5) begin
      n_fail++;
      $display("FAIL single_result_word: %h, want 00a5", result_word);
    end
    n_checks++;
    if (pe_index !== 3'd0 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_end: idx %0d level %0d, want 0 0", pe_index, fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_str, exp_rv;
    apply_reset();
    period = 32'd0;
    for (int c = 1; c <= 24; c++) begin
      in_valid  = (c <= 16);
      in_word   = 16'(16'h0200 + c);
      pe_result = 16'(16'h1000 + c);
      tick();
      exp_str = (c >= 2 && c <= 17);
      exp_rv  = (c == 10 || c == 18);
      n_checks++;
      if (pe_strobe !== exp_str) begin
        n_fail++;
        $display("FAIL b2b_strobe: edge %0d strobe %b, want %b", c, pe_strobe, exp_str);
      end
      if (exp_str) begin
        n_checks++;
        if (pe_index !== 3'(c - 2) || pe_word !== 16'(16'h0200 + c - 1)) begin
          n_fail++;
          $display("FAIL b2b_slot: edge %0d idx %0d word %h, want idx %0d word %h",
                   c, pe_index, pe_word, 3'(c - 2), 16'(16'h0200 + c - 1));
        end
      end
      n_checks++;
      if (result_valid !== exp_rv) begin
        n_fail++;
        $display("FAIL b2b_result_valid: edge %0d valid %b, want %b", c, result_valid, exp_rv);
      end
      if (c == 10 || c == 18) begin
        n_checks++;
        if (result_word !== 16'(16'h1000 + c)) begin
          n_fail++;
          $display("FAIL b2b_result_word: edge %0d word %h, want %h", c, result_word, 16'(16'h1000 + c));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_underflow();
    logic exp_str;
    int k, n_res, res_cyc;
    apply_reset();
    period    = 32'd2;
    pe_result = 16'h0BEE;
    k = 0; n_res = 0; res_cyc = -1;
    for (int c = 1; c <= 45; c++) begin
      in_valid = (c <= 3) || (c >= 24 && c <= 28);
      in_word  = 16'(c);
      tick();
      exp_str = (c inside {2, 5, 8, 25, 28, 31, 34, 37});
      n_checks++;
      if (pe_strobe !== exp_str) begin
        n_fail++;
        $display("FAIL stall_strobe: edge %0d strobe %b, want %b", c, pe_strobe, exp_str);
      end
      if (pe_strobe === 1'b1) begin
        n_checks++;
        if (pe_index !== 3'(k)) begin
          n_fail++;
          $display("FAIL stall_index: edge %0d idx %0d, want %0d", c, pe_index, k);
        end
        k++;
      end
      if (c >= 12 && c <= 24) begin
        n_checks++;
        if (pe_index !== 3'd3) begin
          n_fail++;
          $display("FAIL stall_hold: edge %0d idx %0d, want 3", c, pe_index);
        end
      end
      if (result_valid === 1'b1) begin
        n_res++;
        res_cyc = c;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_res != 1 || res_cyc != 40 || result_word !== 16'h0BEE) begin
      n_fail++;
      $display("FAIL stall_result: count %0d edge %0d word %h, want 1 40 0bee", n_res, res_cyc, result_word);
    end
  endtask

  task automatic test_backpressure();
    int acc, exp_level;
    logic pre_ready, exp_ready;
    apply_reset();
    period = 32'd100;
    acc = 0;
    for (int c = 1; c <= 106; c++) begin
      in_valid  = (acc < 20);
      in_word   = 16'(100 + acc);
      pre_ready = in_ready;
      tick();
      if (pre_ready && in_valid) acc++;
      exp_ready = (c <= 16) || (c == 103);
      if (c == 1)        exp_level = 1;
      else if (c <= 17)  exp_level = c - 1;
      else if (c <= 102) exp_level = 16;
      else if (c == 103) exp_level = 15;
      else               exp_level = 16;
      n_checks++;
      if (in_ready !== exp_ready || fifo_level !== 5'(exp_level)) begin
        n_fail++;
        $display("FAIL bp_level: edge %0d ready %b level %0d, want %b %0d",
                 c, in_ready, fifo_level, exp_ready, exp_level);
      end
      if (c == 2 || c == 103) begin
        n_checks++;
        if (pe_strobe !== 1'b1 || pe_word !== ((c == 2) ? 16'd100 : 16'd101)) begin
          n_fail++;
          $display("FAIL bp_pop: edge %0d strobe %b word %0d", c, pe_strobe, pe_word);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc != 18) begin
      n_fail++;
      $display("FAIL bp_accepted: %0d words, want 18", acc);
    end
  endtask

  task automatic test_clear_reset();
    int n_res;
    apply_reset();
    period    = 32'd1;
    pe_result = 16'h0CCC;
    n_res = 0;
    for (int c = 1; c <= 10; c++) begin
      in_valid = 1'b1;
      in_word  = 16'(16'h0300 + c);
      tick();
      if (result_valid === 1'b1) n_res++;
    end
    n_checks++;
    if (pe_index !== 3'd4 || pe_strobe !== 1'b1 || fifo_level !== 5'd5) begin
      n_fail++;
      $display("FAIL clear_pre: idx %0d strobe %b level %0d, want 4 1 5", pe_index, pe_strobe, fifo_level);
    end
    clear    = 1'b1;
    in_word  = 16'h03FF;
    tick();
    if (result_valid === 1'b1) n_res++;
    n_checks++;
    if (fifo_level !== 5'd0 || pe_index !== 3'd0 || pe_strobe !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_state: level %0d idx %0d strobe %b ready %b, want 0 0 0 1",
               fifo_level, pe_index, pe_strobe, in_ready);
    end
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (result_valid === 1'b1) n_res++;
      n_checks++;
      if (pe_strobe !== 1'b0 || fifo_level !== 5'd0) begin
        n_fail++;
        $display("FAIL clear_drop: cycle %0d strobe %b level %0d, want 0 0", c, pe_strobe, fifo_level);
      end
    end
    n_checks++;
    if (n_res != 0) begin
      n_fail++;
      $display("FAIL clear_no_result: %0d pulses, want 0", n_res);
    end

    for (int c = 1; c <= 4; c++) begin
      in_valid = 1'b1;
      in_word  = 16'(16'h0400 + c);
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (pe_word !== 16'h0402 || pe_index !== 3'd1 || pe_strobe !== 1'b1 || fifo_level !== 5'd2) begin
      n_fail++;
      $display("FAIL rst_pre: word %h idx %0d strobe %b level %0d, want 0402 1 1 2",
               pe_word, pe_index, pe_strobe, fifo_level);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (pe_word !== 16'h0 || pe_index !== 3'd0 || pe_strobe !== 1'b0 || result_valid !== 1'b0 ||
        result_word !== 16'h0 || fifo_level !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: word %h idx %0d strobe %b rv %b rw %h level %0d ready %b",
               pe_word, pe_index, pe_strobe, result_valid, result_word, fifo_level, in_ready);
    end
    apply_reset();
  endtask

  task automatic test_period_change();
    logic exp_str;
    apply_reset();
    period = 32'd5;
    for (int c = 1; c <= 16; c++) begin
      in_valid = (c <= 3);
      in_word  = 16'(16'h0500 + c);
      if (c == 4) period = 32'd1;
      tick();
      exp_str = (c inside {2, 8, 10});
      n_checks++;
      if (pe_strobe !== exp_str) begin
        n_fail++;
        $display("FAIL period_strobe: edge %0d strobe %b, want %b", c, pe_strobe, exp_str);
      end
      if (c == 8) begin
        n_checks++;
        if (pe_word !== 16'h0502 || pe_index !== 3'd1) begin
          n_fail++;
          $display("FAIL period_slot1: word %h idx %0d, want 0502 1", pe_word, pe_index);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underflow();
    test_backpressure();
    test_clear_reset();
    test_period_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
